// File: rtl/soc_cpu_div_cell_if.sv
// Handshake and operand/result bundle between the M stage and the divider cell.
interface soc_cpu_div_cell_if #(
  parameter int WIDTH = 32
);
  logic             M_div_start;
  logic             M_div_signed;
  logic [WIDTH-1:0] M_div_src1;
  logic [WIDTH-1:0] M_div_src2;
  logic             M_div_busy;
  logic             M_div_done;
  logic [WIDTH-1:0] M_div_quotient;
  logic [WIDTH-1:0] M_div_remainder;

  modport master (
    output M_div_start, M_div_signed, M_div_src1, M_div_src2,
    input  M_div_busy, M_div_done, M_div_quotient, M_div_remainder
  );

  modport slave (
    input  M_div_start, M_div_signed, M_div_src1, M_div_src2,
    output M_div_busy, M_div_done, M_div_quotient, M_div_remainder
  );
endinterface

// File: rtl/soc_cpu_div_cell.sv
// Iterative radix-2 restoring divider (signed/unsigned), one quotient bit per cycle.
// Optional SOC_CPU_DIV_EARLY_OUT_EN: skip iteration when divisor is zero or |dividend| < |divisor|.
module soc_cpu_div_cell #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  soc_cpu_div_cell_if.slave   div_if
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             signed_q, q_neg_q, r_neg_q, div0_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] dvd_q;   // dividend shifts out MSB-first while quotient bits shift in
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] src1_q;
  logic [WIDTH-1:0] quo_q, remo_q;

  logic             src1_neg, src2_neg;
  logic [WIDTH-1:0] mag1, mag2, partial, fix_quo, fix_rem;
  logic [WIDTH:0]   diff;

  assign src1_neg = div_if.M_div_signed & div_if.M_div_src1[WIDTH-1];
  assign src2_neg = div_if.M_div_signed & div_if.M_div_src2[WIDTH-1];
  assign mag1     = src1_neg ? -div_if.M_div_src1 : div_if.M_div_src1;
  assign mag2     = src2_neg ? -div_if.M_div_src2 : div_if.M_div_src2;

  // rem_q < 2^(iterations done) so its MSB is always zero before the final shift.
  assign partial  = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
  assign diff     = {1'b0, partial} - {1'b0, dsr_q};

  assign fix_quo  = div0_q ? '1 : ((signed_q && q_neg_q) ? -dvd_q : dvd_q);
  assign fix_rem  = div0_q ? src1_q : ((signed_q && r_neg_q) ? -rem_q : rem_q);

`ifdef SOC_CPU_DIV_EARLY_OUT_EN
  logic early_out;
  assign early_out = (mag2 == '0) || (mag1 < mag2);
`endif

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      signed_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dvd_q    <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      src1_q   <= '0;
      quo_q    <= '0;
      remo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A start coinciding with the done pulse is dropped, not queued.
          if (div_if.M_div_start && !done_q) begin
            signed_q <= div_if.M_div_signed;
            q_neg_q  <= src1_neg ^ src2_neg;
            r_neg_q  <= src1_neg;
            div0_q   <= (div_if.M_div_src2 == '0);
            dsr_q    <= mag2;
            src1_q   <= div_if.M_div_src1;
            busy_q   <= 1'b1;
            cnt_q    <= CNT_W'(WIDTH - 1);
`ifdef SOC_CPU_DIV_EARLY_OUT_EN
            if (early_out) begin
              dvd_q   <= '0;
              rem_q   <= mag1;
              state_q <= S_FIX;
            end else begin
              dvd_q   <= mag1;
              rem_q   <= '0;
              state_q <= S_ITER;
            end
`else
            dvd_q   <= mag1;
            rem_q   <= '0;
            state_q <= S_ITER;
`endif
          end
        end
        S_ITER: begin
          rem_q <= diff[WIDTH] ? partial : diff[WIDTH-1:0];
          dvd_q <= {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) state_q <= S_FIX;
        end
        S_FIX: begin
          quo_q   <= fix_quo;
          remo_q  <= fix_rem;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign div_if.M_div_busy      = busy_q;
  assign div_if.M_div_done      = done_q;
  assign div_if.M_div_quotient  = quo_q;
  assign div_if.M_div_remainder = remo_q;

endmodule

// File: tb/tb_soc_cpu_div_cell.sv
// Scoreboard bench for soc_cpu_div_cell: directed vectors, decoupled done-monitor.
// Latency expectations follow SOC_CPU_DIV_EARLY_OUT_EN when it is defined.
module tb_soc_cpu_div_cell;
  localparam int W = 32;
`ifdef SOC_CPU_DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  soc_cpu_div_cell_if #(.WIDTH(W)) dif ();

  soc_cpu_div_cell #(.WIDTH(W), .CNT_W(5)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .div_if  (dif)
  );

  typedef struct {
    string        name;
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           done_cyc;
    int           busy_n;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   busy_cnt = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts busy cycles and checks every done pulse against the scoreboard.
  always @(negedge clk) begin
    if (!reset_n) begin
      busy_cnt = 0;
    end else begin
      if (dif.M_div_busy) busy_cnt++;
      if (dif.M_div_done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          mon_e = sb.pop_front();
          check({mon_e.name, "_quo"},  dif.M_div_quotient,  mon_e.q);
          check({mon_e.name, "_rem"},  dif.M_div_remainder, mon_e.r);
          check({mon_e.name, "_done_cycle"}, W'(cyc), W'(mon_e.done_cyc));
          check({mon_e.name, "_busy_cycles"}, W'(busy_cnt), W'(mon_e.busy_n));
          check({mon_e.name, "_busy_in_done"}, W'(dif.M_div_busy), W'(0));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic drive(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    dif.M_div_start  = 1'b1;
    dif.M_div_signed = sgn;
    dif.M_div_src1   = a;
    dif.M_div_src2   = b;
  endtask

  // Returns at the first negedge after edge k, i.e. cycle k+1.
  task automatic issue(input string name, input bit sgn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] q,
                       input logic [W-1:0] r, input bit early);
    exp_t e;
    int   lat;
    @(negedge clk);
    lat        = (EARLY && early) ? 2 : W + 2;
    e.name     = name;
    e.q        = q;
    e.r        = r;
    e.done_cyc = cyc + lat;
    e.busy_n   = lat - 1;
    sb.push_back(e);
    drive(sgn, a, b);
    @(negedge clk);
    dif.M_div_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no done within 200 cycles expected done", name);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input string name, input bit sgn, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] q,
                     input logic [W-1:0] r, input bit early);
    issue(name, sgn, a, b, q, r, early);
    wait_done(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    int dc;
    dif.M_div_start  = 1'b0;
    dif.M_div_signed = 1'b0;
    dif.M_div_src1   = '0;
    dif.M_div_src2   = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", W'(dif.M_div_busy), W'(0));
    check("reset_done", W'(dif.M_div_done), W'(0));
    check("reset_quo",  dif.M_div_quotient,  '0);
    check("reset_rem",  dif.M_div_remainder, '0);
    reset_n = 1'b1;
    @(negedge clk);

    //   name          sgn  src1          src2          quotient      remainder     early
    run("u100_7",      0, 32'd100,      32'd7,        32'd14,       32'd2,        0);
    run("s_m7_2",      1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 0);
    run("s_7_m2",      1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        0);
    run("s_m100_7",    1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 0);
    run("u_div0",      0, 32'h00001234, 32'd0,        32'hFFFFFFFF, 32'h00001234, 1);
    run("s_div0",      1, 32'h00001234, 32'd0,        32'hFFFFFFFF, 32'h00001234, 1);
    run("s_div0_neg",  1, 32'hFFFFFF00, 32'd0,        32'hFFFFFFFF, 32'hFFFFFF00, 1);
    run("s_ovf",       1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        0);
    run("u_max_1",     0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        0);
    run("u_max_maxm1", 0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1,        32'd1,        0);
    run("u_big",       0, 32'h12345678, 32'h00001234, 32'h00010004, 32'h00000DA8, 0);
    run("u_3_10",      0, 32'd3,        32'd10,       32'd0,        32'd3,        1);
    run("u_10_0",      0, 32'h10,       32'd0,        32'hFFFFFFFF, 32'h10,       1);
    run("s_m3_10",     1, 32'hFFFFFFFD, 32'd10,       32'd0,        32'hFFFFFFFD, 1);
    run("u_lt_max",    0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFE, 1);

    // Start pulsed in cycle k+10 while busy must be ignored.
    issue("ign_busy", 0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
    s = cyc;
    while (cyc < s + 9) @(negedge clk);
    drive(0, 32'd50, 32'd5);
    @(negedge clk);
    dif.M_div_start = 1'b0;
    wait_done("ign_busy");

    // Start held during the done cycle must be ignored.
    issue("ign_done", 0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 0);
    dc = sb[$].done_cyc;
    while (cyc < dc) @(negedge clk);
    drive(0, 32'd3, 32'd10);
    @(negedge clk);
    dif.M_div_start = 1'b0;
    check("ign_done_busy_after", W'(dif.M_div_busy), W'(0));
    wait_done("ign_done");
    repeat (4) @(negedge clk);

    // Reset in cycle k+20 abandons the op with no done and zeroed outputs.
    issue("rst_abort", 0, 32'd1000, 32'd3, 32'd333, 32'd1, 0);
    s = cyc;
    while (cyc < s + 19) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_busy", W'(dif.M_div_busy), W'(0));
    check("rst_done", W'(dif.M_div_done), W'(0));
    check("rst_quo",  dif.M_div_quotient,  '0);
    check("rst_rem",  dif.M_div_remainder, '0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run("post_rst", 0, 32'd1000, 32'd3, 32'd333, 32'd1, 0);
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
